// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised 1w1r SRAM model.
// Contents: mask-lane helpers, legal read-latency bounds, and the read-result
// flag struct carried alongside the data through the read pipe.
package sram_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Status flags travelling with each read result
  typedef struct packed {
    logic uninit;
    logic err;
    logic coll;
  } rd_flags_t;

  // Number of write-mask lanes in a word
  function automatic int unsigned lane_count(input int unsigned data_w,
                                             input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  // Bit offset of the LSB of a given lane
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned lane_w);
    return lane * lane_w;
  endfunction

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_wmask_merge.sv
// Lane-wise merge of an old word with a new word under a write mask.
// Ports:
//   old_word_i  word before the write
//   new_word_i  incoming write data
//   mask_i      per-lane select, 1 = take the lane from new_word_i
//   merged_c_o  combinational merged word
module sram_wmask_merge
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned WMASK_WIDTH = 32,
  localparam int unsigned NUM_WMASKS = lane_count(DATA_WIDTH, WMASK_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_word_i,
  input  logic [DATA_WIDTH-1:0] new_word_i,
  input  logic [NUM_WMASKS-1:0] mask_i,
  output logic [DATA_WIDTH-1:0] merged_c_o
);

  always_comb begin
    merged_c_o = old_word_i;
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      if (mask_i[i]) begin
        merged_c_o[lane_lsb(i, WMASK_WIDTH) +: WMASK_WIDTH] =
          new_word_i[lane_lsb(i, WMASK_WIDTH) +: WMASK_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sram_1w1r_param.sv
// Parametrised 1-write/1-read synchronous SRAM behavioural model.
// Tracks per-lane initialisation, flags out-of-range reads and same-address
// write/read collisions, and delivers read results after RD_LAT (1 or 2) cycles.
// Optional feature macro: SRAM_1W1R_BYPASS_EN
//   defined   -> collision reads are write-first (new data, post-write init bits)
//   undefined -> collision reads are read-first (stored data, pre-write init bits)
// Ports:
//   clk0, rst0_n  clock, asynchronous active-low reset
//   csb0, wmask0, addr0, din0  write port (csb0 active low, wmask0 per lane)
//   csb1, addr1                read port (csb1 active low)
//   dout1, dout1_vld           read data and its one-cycle valid strobe
//   rd_uninit1, rd_err1, coll1 read status flags, qualified by dout1_vld
module sram_1w1r_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned WMASK_WIDTH = 32,
  parameter int unsigned NUM_WORDS   = 28,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned RD_LAT      = 1,
  localparam int unsigned NUM_WMASKS = lane_count(DATA_WIDTH, WMASK_WIDTH)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  rd_uninit1,
  output logic                  rd_err1,
  output logic                  coll1
);

  // One extra bit so NUM_WORDS == 2**ADDR_WIDTH compares correctly
  localparam int unsigned CMP_W = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    rd_flags_t             flags;
  } rd_res_t;

  // Elaboration-time parameter checks
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("sram_1w1r_param: RD_LAT must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_wmask
    $error("sram_1w1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if ((NUM_WORDS < 2) || (NUM_WORDS > (1 << ADDR_WIDTH))) begin : g_bad_words
    $error("sram_1w1r_param: NUM_WORDS out of range for ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q  [NUM_WORDS];
  logic [NUM_WMASKS-1:0] init_q [NUM_WORDS];

  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  rd_in_range_c;
  logic                  coll_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic [DATA_WIDTH-1:0] rd_raw_c;
  logic [NUM_WMASKS-1:0] rd_init_c;
  rd_res_t               rd_res_d;

  assign wr_en_c       = !csb0 && (CMP_W'(addr0) < CMP_W'(NUM_WORDS));
  assign rd_en_c       = !csb1;
  assign rd_in_range_c = CMP_W'(addr1) < CMP_W'(NUM_WORDS);
  assign coll_c        = wr_en_c && rd_en_c && (addr0 == addr1);

  // Post-write word; also the write-first collision result since addr0 == addr1
  sram_wmask_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH)
  ) u_wr_merge (
    .old_word_i(mem_q[addr0]),
    .new_word_i(din0),
    .mask_i    (wmask0),
    .merged_c_o(wr_word_c)
  );

`ifdef SRAM_1W1R_BYPASS_EN
  assign rd_raw_c  = coll_c ? wr_word_c : mem_q[addr1];
  assign rd_init_c = coll_c ? (init_q[addr1] | wmask0) : init_q[addr1];
`else
  assign rd_raw_c  = mem_q[addr1];
  assign rd_init_c = init_q[addr1];
`endif

  // Build the read result; uninitialised lanes read as zero, never array contents
  always_comb begin
    rd_res_d = '0;
    if (!rd_in_range_c) begin
      rd_res_d.flags.err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (rd_init_c[i]) begin
          rd_res_d.data[lane_lsb(i, WMASK_WIDTH) +: WMASK_WIDTH] =
            rd_raw_c[lane_lsb(i, WMASK_WIDTH) +: WMASK_WIDTH];
        end
      end
      rd_res_d.flags.uninit = ~&rd_init_c;
      rd_res_d.flags.coll   = coll_c;
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk0) begin
    if (wr_en_c) begin
      mem_q[addr0] <= wr_word_c;
    end
  end

  // Per-lane init tracking
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        init_q[w] <= '0;
      end
    end else if (wr_en_c) begin
      init_q[addr0] <= init_q[addr0] | wmask0;
    end
  end

  // First read stage; data only loads on accept so outputs hold when idle
  rd_res_t s1_q;
  logic    s1_vld_q;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_en_c;
      if (rd_en_c) begin
        s1_q <= rd_res_d;
      end
    end
  end

  rd_res_t rd_out;
  logic    rd_out_vld;

  if (RD_LAT == 2) begin : g_lat2
    rd_res_t s2_q;
    logic    s2_vld_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
        s2_q     <= '0;
        s2_vld_q <= 1'b0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_q <= s1_q;
        end
      end
    end

    assign rd_out     = s2_q;
    assign rd_out_vld = s2_vld_q;
  end else begin : g_lat1
    assign rd_out     = s1_q;
    assign rd_out_vld = s1_vld_q;
  end

  assign dout1      = rd_out.data;
  assign dout1_vld  = rd_out_vld;
  assign rd_uninit1 = rd_out.flags.uninit;
  assign rd_err1    = rd_out.flags.err;
  assign coll1      = rd_out.flags.coll;

`ifndef SYNTHESIS
  // Simulation notices for collisions and out-of-range accesses
  always @(posedge clk0) begin
    if (rst0_n) begin
      if (coll_c) begin
        $display("%m: write/read collision at addr %0d", addr1);
      end
      if (!csb0 && !wr_en_c) begin
        $display("%m: write to out-of-range addr %0d dropped", addr0);
      end
      if (rd_en_c && !rd_in_range_c) begin
        $display("%m: read from out-of-range addr %0d", addr1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Directed bench for sram_1w1r_param: one instance with RD_LAT = 1 and one
// with RD_LAT = 2 share all inputs; each test task checks the relevant one.
module tb_sram_1w1r_param;

  logic         clk0;
  logic         rst0_n;
  logic         csb0;
  logic [3:0]   wmask0;
  logic [4:0]   addr0;
  logic [127:0] din0;
  logic         csb1;
  logic [4:0]   addr1;

  logic [127:0] d1_dout, d2_dout;
  logic         d1_vld, d1_uninit, d1_err, d1_coll;
  logic         d2_vld, d2_uninit, d2_err, d2_coll;
  logic [3:0]   d1_fl, d2_fl;

  // Flag vectors: {vld, uninit, err, coll}
  assign d1_fl = {d1_vld, d1_uninit, d1_err, d1_coll};
  assign d2_fl = {d2_vld, d2_uninit, d2_err, d2_coll};

  int checks = 0;
  int errors = 0;

  sram_1w1r_param #(.RD_LAT(1)) u_dut1 (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(d1_dout), .dout1_vld(d1_vld),
    .rd_uninit1(d1_uninit), .rd_err1(d1_err), .coll1(d1_coll)
  );

  sram_1w1r_param #(.RD_LAT(2)) u_dut2 (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(d2_dout), .dout1_vld(d2_vld),
    .rd_uninit1(d2_uninit), .rd_err1(d2_err), .coll1(d2_coll)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Advance past the next rising edge; outputs are then stable for sampling
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic set_wr(input logic [4:0] a, input logic [127:0] d, input logic [3:0] m);
    csb0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
  endtask

  task automatic idle();
    csb0 = 1'b1;
    csb1 = 1'b1;
  endtask

  function automatic logic [127:0] pattern(input int a);
    return {4{24'hC0DE5A, 8'(a)}};
  endfunction

  task automatic test_reset();
    rst0_n = 1'b0;
    idle();
    wmask0 = '0; addr0 = '0; din0 = '0; addr1 = '0;
    repeat (2) tick();
    checks++; if (d1_dout !== 128'h0) begin errors++; $display("FAIL reset_d1_dout got %h exp 0", d1_dout); end
    checks++; if (d1_fl !== 4'b0000) begin errors++; $display("FAIL reset_d1_flags got %b exp 0000", d1_fl); end
    checks++; if (d2_dout !== 128'h0) begin errors++; $display("FAIL reset_d2_dout got %h exp 0", d2_dout); end
    checks++; if (d2_fl !== 4'b0000) begin errors++; $display("FAIL reset_d2_flags got %b exp 0000", d2_fl); end
    rst0_n = 1'b1;
    tick();
  endtask

  task automatic test_uninit_read();
    csb1 = 1'b0; addr1 = 5'd3;
    tick();
    idle();
    checks++; if (d1_dout !== 128'h0) begin errors++; $display("FAIL uninit_dout got %h exp 0", d1_dout); end
    checks++; if (d1_fl !== 4'b1100) begin errors++; $display("FAIL uninit_flags got %b exp 1100", d1_fl); end
    checks++; if (d2_fl[3] !== 1'b0) begin errors++; $display("FAIL uninit_lat2_early got %b exp 0", d2_fl[3]); end
    tick();
    checks++; if (d1_vld !== 1'b0) begin errors++; $display("FAIL uninit_strobe got %b exp 0", d1_vld); end
    checks++; if (d2_fl !== 4'b1100) begin errors++; $display("FAIL uninit_lat2_flags got %b exp 1100", d2_fl); end
    tick();
  endtask

  task automatic test_wmask();
    set_wr(5'd5, {4{32'hAAAAAAAA}}, 4'b0101);
    tick();
    idle(); csb1 = 1'b0; addr1 = 5'd5;
    tick();
    idle();
    checks++; if (d1_dout !== 128'h00000000_AAAAAAAA_00000000_AAAAAAAA) begin errors++; $display("FAIL wmask_half_dout got %h exp 00000000aaaaaaaa00000000aaaaaaaa", d1_dout); end
    checks++; if (d1_fl !== 4'b1100) begin errors++; $display("FAIL wmask_half_flags got %b exp 1100", d1_fl); end
    set_wr(5'd5, {4{32'hBBBBBBBB}}, 4'b1010);
    tick();
    idle(); csb1 = 1'b0; addr1 = 5'd5;
    tick();
    idle();
    checks++; if (d1_dout !== 128'hBBBBBBBB_AAAAAAAA_BBBBBBBB_AAAAAAAA) begin errors++; $display("FAIL wmask_full_dout got %h exp bbbbbbbbaaaaaaaabbbbbbbbaaaaaaaa", d1_dout); end
    checks++; if (d1_fl !== 4'b1000) begin errors++; $display("FAIL wmask_full_flags got %b exp 1000", d1_fl); end
    // Zero mask must leave the word untouched
    set_wr(5'd5, 128'h0, 4'b0000);
    tick();
    idle(); csb1 = 1'b0; addr1 = 5'd5;
    tick();
    idle();
    checks++; if (d1_dout !== 128'hBBBBBBBB_AAAAAAAA_BBBBBBBB_AAAAAAAA) begin errors++; $display("FAIL wmask_zero_dout got %h exp bbbbbbbbaaaaaaaabbbbbbbbaaaaaaaa", d1_dout); end
    tick();
  endtask

  task automatic test_collision();
    logic [127:0] nd;
    logic [127:0] exp_full;
    logic [127:0] exp_part;
    nd = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
`ifdef SRAM_1W1R_BYPASS_EN
    exp_full = nd;
    exp_part = 128'h00000000_00000000_0FEDCBA9_87654321;
`else
    exp_full = {4{32'h55555555}};
    exp_part = 128'h0;
`endif
    set_wr(5'd27, {4{32'h55555555}}, 4'hF);
    tick();
    set_wr(5'd27, nd, 4'hF); csb1 = 1'b0; addr1 = 5'd27;
    tick();
    idle();
    checks++; if (d1_dout !== exp_full) begin errors++; $display("FAIL coll_full_dout got %h exp %h", d1_dout, exp_full); end
    checks++; if (d1_fl !== 4'b1001) begin errors++; $display("FAIL coll_full_flags got %b exp 1001", d1_fl); end
    csb1 = 1'b0; addr1 = 5'd27;
    tick();
    idle();
    checks++; if (d1_dout !== nd) begin errors++; $display("FAIL coll_after_dout got %h exp %h", d1_dout, nd); end
    checks++; if (d1_fl !== 4'b1000) begin errors++; $display("FAIL coll_after_flags got %b exp 1000", d1_fl); end
    // Partial-mask collision on a never-written word
    set_wr(5'd10, nd, 4'b0011); csb1 = 1'b0; addr1 = 5'd10;
    tick();
    idle();
    checks++; if (d1_dout !== exp_part) begin errors++; $display("FAIL coll_part_dout got %h exp %h", d1_dout, exp_part); end
    checks++; if (d1_fl !== 4'b1101) begin errors++; $display("FAIL coll_part_flags got %b exp 1101", d1_fl); end
    tick();
  endtask

  task automatic test_out_of_range();
    for (int a = 0; a < 28; a++) begin
      set_wr(5'(a), pattern(a), 4'hF);
      tick();
    end
    idle();
    set_wr(5'd30, {128{1'b1}}, 4'hF); csb1 = 1'b0; addr1 = 5'd30;
    tick();
    idle();
    checks++; if (d1_dout !== 128'h0) begin errors++; $display("FAIL oor30_dout got %h exp 0", d1_dout); end
    checks++; if (d1_fl !== 4'b1010) begin errors++; $display("FAIL oor30_flags got %b exp 1010", d1_fl); end
    csb1 = 1'b0; addr1 = 5'd28;
    tick();
    checks++; if (d1_fl !== 4'b1010) begin errors++; $display("FAIL oor28_flags got %b exp 1010", d1_fl); end
    addr1 = 5'd31;
    tick();
    checks++; if (d1_fl !== 4'b1010) begin errors++; $display("FAIL oor31_flags got %b exp 1010", d1_fl); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    // Reads of every word with no bubbles; also confirms the dropped write left the array intact
    for (int a = 0; a < 28; a++) begin
      csb1 = 1'b0; addr1 = 5'(a);
      tick();
      checks++; if (d1_dout !== pattern(a)) begin errors++; $display("FAIL b2b_dout addr %0d got %h exp %h", a, d1_dout, pattern(a)); end
      checks++; if (d1_fl !== 4'b1000) begin errors++; $display("FAIL b2b_flags addr %0d got %b exp 1000", a, d1_fl); end
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_rd_lat2();
    csb1 = 1'b0; addr1 = 5'd1;
    tick();
    checks++; if (d2_vld !== 1'b0) begin errors++; $display("FAIL lat2_first got %b exp 0", d2_vld); end
    addr1 = 5'd2;
    tick();
    checks++; if ({d2_vld, d2_dout} !== {1'b1, pattern(1)}) begin errors++; $display("FAIL lat2_a1 got %b %h exp 1 %h", d2_vld, d2_dout, pattern(1)); end
    addr1 = 5'd3;
    tick();
    checks++; if ({d2_vld, d2_dout} !== {1'b1, pattern(2)}) begin errors++; $display("FAIL lat2_a2 got %b %h exp 1 %h", d2_vld, d2_dout, pattern(2)); end
    idle();
    tick();
    checks++; if ({d2_vld, d2_dout} !== {1'b1, pattern(3)}) begin errors++; $display("FAIL lat2_a3 got %b %h exp 1 %h", d2_vld, d2_dout, pattern(3)); end
    tick();
    checks++; if ({d2_vld, d2_dout} !== {1'b0, pattern(3)}) begin errors++; $display("FAIL lat2_hold got %b %h exp 0 %h", d2_vld, d2_dout, pattern(3)); end
    tick();
  endtask

  task automatic test_reset_flush();
    csb1 = 1'b0; addr1 = 5'd4;
    tick();
    idle();
    rst0_n = 1'b0;
    #1;
    checks++; if ({d2_fl, d2_dout} !== {4'b0000, 128'h0}) begin errors++; $display("FAIL flush_in_reset got %b %h exp 0000 0", d2_fl, d2_dout); end
    tick();
    rst0_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({d2_fl, d2_dout} !== {4'b0000, 128'h0}) begin errors++; $display("FAIL flush_after_release cycle %0d got %b %h exp 0000 0", c, d2_fl, d2_dout); end
    end
    // Init bits were cleared, so the old contents must not be visible
    csb1 = 1'b0; addr1 = 5'd4;
    tick();
    idle();
    checks++; if ({d1_fl, d1_dout} !== {4'b1100, 128'h0}) begin errors++; $display("FAIL flush_init_cleared got %b %h exp 1100 0", d1_fl, d1_dout); end
    tick();
  endtask

  initial begin
    test_reset();
    test_uninit_read();
    test_wmask();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_rd_lat2();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
